// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: PC, ROM addressing, one-entry output slot with valid/ready,
// Start/Halt sequencing and branch flush. Optional stall counter under FETCH_STALLCNT_EN.
module inst_fetch_unit #(
    parameter int unsigned     AW         = 10,
    parameter int unsigned     IW         = 9,
    parameter logic [AW-1:0]   START_ADDR = '0,
    parameter logic [IW-1:0]   HALT_WORD  = '1
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic [1:0]    BrType,
    input  logic          Zero,
    input  logic          BrRel,
    input  logic [AW-1:0] DestAddr,
    output logic [AW-1:0] InstAddress,
    input  logic [IW-1:0] InstIn,
    output logic [IW-1:0] InstOut,
    output logic [AW-1:0] InstPC,
    output logic          InstValid,
    input  logic          InstReady,
    output logic          Done
`ifdef FETCH_STALLCNT_EN
    ,
    output logic [15:0]   StallCount
`endif
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t        state;
    logic [AW-1:0] pc;

    logic          br_cond;
    logic          br_taken;
    logic [AW-1:0] br_target;
    logic          slot_free;
    logic          halt_in_slot;

    assign InstAddress = pc;

    // Branch resolution; only acted on while running
    always_comb begin
        br_cond = 1'b0;
        case (BrType)
            2'b01:   br_cond = Zero;
            2'b10:   br_cond = ~Zero;
            2'b11:   br_cond = 1'b1;
            default: br_cond = 1'b0;
        endcase
    end

    assign br_taken     = (state == S_RUN) && br_cond;
    assign br_target    = BrRel ? (pc + DestAddr) : DestAddr;
    assign slot_free    = ~InstValid | InstReady;
    // Fetch stops after the halt word is captured, so it can only sit in the slot
    assign halt_in_slot = InstValid && (InstOut == HALT_WORD);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= S_IDLE;
            pc        <= START_ADDR;
            InstOut   <= '0;
            InstPC    <= '0;
            InstValid <= 1'b0;
            Done      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        state <= S_RUN;
                        pc    <= START_ADDR;
                    end
                end
                S_RUN: begin
                    if (br_taken) begin
                        pc        <= br_target;
                        InstValid <= 1'b0;
                    end else if (halt_in_slot) begin
                        if (InstReady) begin
                            state     <= S_HALTED;
                            InstValid <= 1'b0;
                            Done      <= 1'b1;
                        end
                    end else if (slot_free) begin
                        InstOut   <= InstIn;
                        InstPC    <= pc;
                        InstValid <= 1'b1;
                        pc        <= pc + AW'(1);
                    end
                end
                S_HALTED: begin
                    if (Start) begin
                        state <= S_RUN;
                        pc    <= START_ADDR;
                        Done  <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef FETCH_STALLCNT_EN
    // Cycles with a word offered but not taken; saturating, cleared when a program starts
    always_ff @(posedge Clk) begin
        if (Reset) begin
            StallCount <= '0;
        end else if (Start && (state != S_RUN)) begin
            StallCount <= '0;
        end else if (InstValid && !InstReady && (StallCount != 16'hFFFF)) begin
            StallCount <= StallCount + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Scoreboard bench for inst_fetch_unit: a program-flow model pushes expected transfers,
// a negedge monitor pops and compares each accepted instruction.
module tb_inst_fetch_unit;

    localparam int unsigned AW   = 10;
    localparam int unsigned IW   = 9;
    localparam int          MEMN = 1024;
    localparam logic [IW-1:0] HALT = '1;

    localparam int M_IDLE   = 0;
    localparam int M_RUN    = 1;
    localparam int M_HALTED = 2;

    logic          Clk;
    logic          Reset;
    logic          Start;
    logic [1:0]    BrType;
    logic          Zero;
    logic          BrRel;
    logic [AW-1:0] DestAddr;
    logic [AW-1:0] InstAddress;
    logic [IW-1:0] InstIn;
    logic [IW-1:0] InstOut;
    logic [AW-1:0] InstPC;
    logic          InstValid;
    logic          InstReady;
    logic          Done;
`ifdef FETCH_STALLCNT_EN
    logic [15:0]   StallCount;
`endif

    inst_fetch_unit dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Start       (Start),
        .BrType      (BrType),
        .Zero        (Zero),
        .BrRel       (BrRel),
        .DestAddr    (DestAddr),
        .InstAddress (InstAddress),
        .InstIn      (InstIn),
        .InstOut     (InstOut),
        .InstPC      (InstPC),
        .InstValid   (InstValid),
        .InstReady   (InstReady),
        .Done        (Done)
`ifdef FETCH_STALLCNT_EN
        ,
        .StallCount  (StallCount)
`endif
    );

    logic [IW-1:0] rom [0:MEMN-1];
    assign InstIn = rom[InstAddress];

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [IW-1:0] word;
    } xfer_t;

    xfer_t exp_q[$];

    int checks = 0;
    int passes = 0;

    // Reference model of the fetch stream
    int            m_state;
    int            m_pc;
    bit            m_valid;
    bit            m_done;
    int            m_slot_pc;
    logic [IW-1:0] m_word;
    int            m_stall;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_state   = M_IDLE;
        m_pc      = 0;
        m_valid   = 1'b0;
        m_done    = 1'b0;
        m_slot_pc = 0;
        m_word    = '0;
        m_stall   = 0;
        exp_q.delete();
    endtask

    // Applies one cycle of inputs to the model
    task automatic model_step(input bit st, input logic [1:0] bt, input bit z,
                              input bit rel, input logic [AW-1:0] dest, input bit rdy);
        bit taken;
        int tgt;
        taken = (bt == 2'b11) || (bt == 2'b01 && z) || (bt == 2'b10 && !z);
        tgt   = rel ? (m_pc + int'(dest)) % MEMN : int'(dest);
        if (st && m_state != M_RUN) m_stall = 0;
        else if (m_valid && !rdy && m_stall < 65535) m_stall++;
        case (m_state)
            M_IDLE: if (st) begin
                m_state = M_RUN;
                m_pc    = 0;
            end
            M_HALTED: if (st) begin
                m_state = M_RUN;
                m_pc    = 0;
                m_done  = 1'b0;
            end
            default: begin
                if (taken) begin
                    if (m_valid && !rdy) void'(exp_q.pop_front());
                    m_valid = 1'b0;
                    m_pc    = tgt;
                end else if (m_valid && m_word == HALT) begin
                    if (rdy) begin
                        m_valid = 1'b0;
                        m_done  = 1'b1;
                        m_state = M_HALTED;
                    end
                end else if (!m_valid || rdy) begin
                    m_word    = rom[m_pc];
                    m_slot_pc = m_pc;
                    m_valid   = 1'b1;
                    exp_q.push_back({AW'(m_pc), rom[m_pc]});
                    m_pc      = (m_pc + 1) % MEMN;
                end
            end
        endcase
    endtask

    task automatic check_outputs();
        chk("inst_address", 32'(InstAddress), 32'(m_pc));
        chk("inst_valid", 32'(InstValid), 32'(m_valid));
        chk("done", 32'(Done), 32'(m_done));
        if (m_valid) begin
            chk("slot_pc", 32'(InstPC), 32'(m_slot_pc));
            chk("slot_word", 32'(InstOut), 32'(m_word));
        end
`ifdef FETCH_STALLCNT_EN
        chk("stall_count", 32'(StallCount), 32'(m_stall));
`endif
    endtask

    // Called at posedge+1: check current state, drive this cycle, advance one clock
    task automatic cycle(input bit st, input logic [1:0] bt, input bit z,
                         input bit rel, input logic [AW-1:0] dest, input bit rdy);
        check_outputs();
        Start     = st;
        BrType    = bt;
        Zero      = z;
        BrRel     = rel;
        DestAddr  = dest;
        InstReady = rdy;
        model_step(st, bt, z, rel, dest, rdy);
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_inputs();
        Start = 1'b0; BrType = 2'b00; Zero = 1'b0; BrRel = 1'b0;
        DestAddr = '0; InstReady = 1'b0;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        idle_inputs();
        model_reset();
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        chk("rst_address", 32'(InstAddress), 32'd0);
        chk("rst_valid", 32'(InstValid), 32'd0);
        chk("rst_done", 32'(Done), 32'd0);
        chk("rst_out", 32'(InstOut), 32'd0);
        chk("rst_pc", 32'(InstPC), 32'd0);
`ifdef FETCH_STALLCNT_EN
        chk("rst_stall", 32'(StallCount), 32'd0);
`endif
    endtask

    // Run until the halt word sits in the slot, bounded
    task automatic run_to_halt_slot();
        bit found;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (m_valid && m_word == HALT) found = 1'b1;
            else cycle(0, 2'b00, 0, 0, '0, 1);
        end
        chk("halt_reached", 32'(found), 32'd1);
    endtask

    // Scoreboard monitor: every accepted instruction must match the next expected transfer
    always @(negedge Clk) begin
        if (!Reset && InstValid && InstReady) begin
            if (exp_q.size() == 0) begin
                chk("xfer_unexpected", 32'(InstPC), 32'hFFFF_FFFF);
            end else begin
                xfer_t e;
                e = exp_q.pop_front();
                chk("xfer_pc", 32'(InstPC), 32'(e.pc));
                chk("xfer_word", 32'(InstOut), 32'(e.word));
            end
        end
    end

    initial begin
        for (int i = 0; i < MEMN; i++) rom[i] = IW'($urandom_range(0, 510));
        rom[100] = 9'b001_011_010;
        rom[50]  = 9'b000_001_100;
        Reset = 1'b1;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge Clk);
        #1;
        do_reset();

        // Sequential fetch from START_ADDR
        cycle(1, 2'b00, 0, 0, '0, 1);
        chk("start_addr", 32'(InstAddress), 32'd0);
        for (int i = 0; i < 15; i++) cycle(0, 2'b00, 0, 0, '0, 1);

        // JmpEq taken, absolute
        cycle(0, 2'b01, 1, 0, AW'(100), 1);
        chk("jeq_addr", 32'(InstAddress), 32'd100);
        chk("jeq_bubble", 32'(InstValid), 32'd0);
        cycle(0, 2'b00, 0, 0, '0, 1);
        chk("jeq_pc", 32'(InstPC), 32'd100);
        chk("jeq_word", 32'(InstOut), 32'(9'b001_011_010));
        // JmpEq not taken
        for (int i = 0; i < 3; i++) cycle(0, 2'b01, 0, 0, AW'(100), 1);

        // JmpNe taken
        cycle(0, 2'b10, 0, 0, AW'(50), 1);
        cycle(0, 2'b00, 0, 0, '0, 1);
        chk("jne_word", 32'(InstOut), 32'(9'b000_001_100));

        // Unconditional relative branch wrapping past the top of the address space
        cycle(0, 2'b11, 0, 0, AW'(1020), 1);
        cycle(0, 2'b11, 0, 1, AW'(10), 1);
        chk("rel_wrap", 32'(InstAddress), 32'd6);
        // Sequential wrap 1022 -> 1023 -> 0
        cycle(0, 2'b11, 0, 0, AW'(1022), 1);
        for (int i = 0; i < 4; i++) cycle(0, 2'b00, 0, 0, '0, 1);

        // Stall for 4 cycles, then resume
        for (int i = 0; i < 4; i++) cycle(0, 2'b00, 0, 0, '0, 0);
        for (int i = 0; i < 4; i++) cycle(0, 2'b00, 0, 0, '0, 1);

        // Halt at address 5, stalled for a while before acceptance
        rom[5] = HALT;
        cycle(0, 2'b11, 0, 0, AW'(0), 1);
        run_to_halt_slot();
        cycle(0, 2'b00, 0, 0, '0, 0);
        cycle(0, 2'b00, 0, 0, '0, 0);
        cycle(0, 2'b00, 0, 0, '0, 1);
        chk("halt_done", 32'(Done), 32'd1);
        chk("halt_valid", 32'(InstValid), 32'd0);
        cycle(0, 2'b11, 0, 0, AW'(300), 1);
        cycle(0, 2'b00, 0, 0, '0, 1);
        rom[5] = IW'(9'h0AA);
        cycle(1, 2'b00, 0, 0, '0, 1);
        chk("restart_done", 32'(Done), 32'd0);
        chk("restart_addr", 32'(InstAddress), 32'd0);
        for (int i = 0; i < 6; i++) cycle(0, 2'b00, 0, 0, '0, 1);

        // Reset mid-run with a valid slot
        cycle(0, 2'b00, 0, 0, '0, 0);
        do_reset();

        // Branch and halt in the same cycle: branch wins
        rom[5] = HALT;
        cycle(1, 2'b00, 0, 0, '0, 1);
        run_to_halt_slot();
        cycle(0, 2'b11, 0, 0, AW'(200), 1);
        chk("br_over_halt_done", 32'(Done), 32'd0);
        for (int i = 0; i < 3; i++) cycle(0, 2'b00, 0, 0, '0, 1);

        // Randomized traffic with halts reachable and occasional restarts
        rom[777] = HALT;
        for (int i = 0; i < 400; i++) begin
            bit            st;
            logic [1:0]    bt;
            st = ($urandom_range(0, 9) == 0);
            bt = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            cycle(st, bt, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  AW'($urandom_range(0, MEMN - 1)), ($urandom_range(0, 3) != 0));
        end
        check_outputs();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/inst_fetch_unit.md
# inst_fetch_unit

Parametrised instruction fetch stage: owns the program counter, drives the address of the external combinational instruction ROM, and registers the fetched word into a one-entry output slot with a valid/ready handshake toward decode. Adds Start/Halt sequencing, conditional and unconditional branches, absolute or PC-relative targets, and flush on taken branch. Sits between the instruction ROM and the decode stage, replacing the bare program counter.

## Interface
- AW, 10, PC / instruction address width
- IW, 9, instruction word width
- START_ADDR, 0, PC value loaded on reset and on every Start
- HALT_WORD, all ones (IW bits), instruction encoding that ends the program
- Clk  in  1  clock, all state updates on rising edge
- Reset  in  1  synchronous, active-high reset
- Start  in  1  pulse; begins fetching at START_ADDR from IDLE or HALTED
- BrType  in  2  branch request from execute: 00 none, 01 JmpEq (taken if Zero=1), 10 JmpNe (taken if Zero=0), 11 unconditional
- Zero  in  1  ALU zero flag qualifying BrType 01/10
- BrRel  in  1  1: target = PC + DestAddr (two's complement, mod 2^AW); 0: target = DestAddr
- DestAddr  in  AW  branch target or offset
- InstAddress  out  AW  current PC, drives ROM address
- InstIn  in  IW  ROM data for InstAddress (same cycle)
- InstOut  out  IW  registered instruction to decode
- InstPC  out  AW  address InstOut was fetched from
- InstValid  out  1  InstOut/InstPC valid
- InstReady  in  1  decode accepts InstOut this cycle
- Done  out  1  high while in HALTED

## Operation
- States: IDLE, RUN, HALTED. Reset → IDLE.
- IDLE: no fetch; PC held at START_ADDR. Start → RUN, PC ← START_ADDR.
- RUN, "slot free" = !InstValid or (InstValid and InstReady). When slot free: InstOut ← InstIn, InstPC ← PC, InstValid ← 1, PC ← PC+1 (wraps 2^AW−1 → 0). When slot occupied and not ready: PC, InstOut, InstPC held (stall).
- Halt: word captured equal to HALT_WORD stops further fetch (PC held). Once that word is accepted (InstValid and InstReady) → HALTED, InstValid ← 0, Done ← 1.
- HALTED: no fetch, branches ignored. Start → RUN, PC ← START_ADDR, Done ← 0.
- Branch taken (RUN only): PC ← target, InstValid ← 0 (flush), normal fetch/capture suppressed that cycle; pending HALT_WORD in slot is discarded. Branch has priority over stall, capture and halt.
- Branch not taken: no effect; fetch proceeds normally.
- Start while in RUN: ignored.
- Relative target uses current PC register value, not InstPC.

## Timing
- Reset values: state IDLE, PC = START_ADDR, InstAddress = START_ADDR, InstOut = 0, InstPC = 0, InstValid = 0, Done = 0.
- Start sampled cycle n → RUN at n+1 with InstAddress = START_ADDR; InstValid = 1 with ROM[START_ADDR] at n+2.
- Steady state with InstReady held 1: one instruction per cycle, PC advances every cycle.
- Taken branch sampled cycle n → n+1: InstValid = 0, InstAddress = target; n+2: InstValid = 1, InstOut = ROM[target], InstPC = target.
- Halt word accepted cycle n → Done = 1, InstValid = 0 at n+1.
- Reset mid-operation overrides everything; outputs at reset values next cycle.

## Configuration
- FETCH_STALLCNT_EN defined: adds output StallCount (16 bits), reset 0, increments every cycle with InstValid=1 and InstReady=0, saturates at 0xFFFF, cleared on Start.
- Not defined: port and counter absent; functional behaviour otherwise identical.

## Test plan
- Reset, Start pulse, InstReady=1, no branches, 15 cycles → InstPC sequence 0,1,2…, InstOut = ROM[InstPC] each cycle, Done = 0.
- BrType=01, Zero=1, BrRel=0, DestAddr=100 → after one bubble InstPC=100, InstOut=9'b001_011_010; same with Zero=0 → not taken, PC continues sequentially.
- BrType=10, Zero=0, DestAddr=50 → InstOut=9'b000_001_100 two cycles later; BrType=11 with BrRel=1, PC=1020, DestAddr=10 → target wraps to 6.
- InstReady=0 for 4 cycles with InstValid=1 → InstOut/InstPC/InstAddress frozen; StallCount (if enabled) +4; fetch resumes without loss or duplicate.
- ROM word HALT_WORD at address 5 → fetch stops, after acceptance Done=1, InstValid=0; Start → RUN from START_ADDR, Done=0.
- Reset asserted mid-RUN with InstValid=1 → next cycle IDLE, all outputs at reset values; branch and halt in same cycle → branch wins, Done stays 0.
